// File: rtl/pipeline_ctrl_if.sv
// Pipeline controller bus: ID/EX opcode slice, branch resolution, resume in;
// stage enables, redirect, status and retired count out.
interface pipeline_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 32
);
  logic              id_valid;
  logic [15:0]       id_opcode;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              resume;
  logic              fetch_en;
  logic              decode_en;
  logic              exec_en;
  logic              flush;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;
  logic              halted;
  logic              mul_busy;
  logic [CNT_W-1:0]  insn_count;

  modport master (
    output id_valid, id_opcode, br_taken, br_target, resume,
    input  fetch_en, decode_en, exec_en, flush, pc_load, pc_target,
           halted, mul_busy, insn_count
  );

  modport slave (
    input  id_valid, id_opcode, br_taken, br_target, resume,
    output fetch_en, decode_en, exec_en, flush, pc_load, pc_target,
           halted, mul_busy, insn_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Execute-stage sequencer: MUL stall, taken-branch redirect/flush, halt/resume
// and a saturating retired-instruction counter. All outputs registered.
module pipeline_ctrl #(
  parameter int MUL_LAT   = 3,
  parameter int FLUSH_CYC = 2,
  parameter int ADDR_W    = 16,
  parameter int CNT_W     = 32
) (
  input logic             clock,
  input logic             reset,
  pipeline_ctrl_if.slave  bus
);
  localparam int MAXC = (MUL_LAT > FLUSH_CYC) ? MUL_LAT : FLUSH_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [15:0] OP_BR  = 16'h0009;
  localparam logic [15:0] OP_BNE = 16'h000A;
  localparam logic [15:0] OP_MUL = 16'h000D;
  localparam logic [15:0] OP_HLT = 16'h000E;

  typedef enum logic [1:0] {RUN, MUL_WAIT, FLUSH, HALTED} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              fetch_en_q, decode_en_q, exec_en_q, flush_q, pc_load_q;
  logic              halted_q, mul_busy_q;
  logic [ADDR_W-1:0] pc_target_q;
  logic [CNT_W-1:0]  insn_count_q, insn_count_d;

  always_comb begin
    insn_count_d = insn_count_q;
    if (insn_count_q != '1) insn_count_d = insn_count_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      fetch_en_q   <= 1'b1;
      decode_en_q  <= 1'b1;
      exec_en_q    <= 1'b1;
      flush_q      <= 1'b0;
      pc_load_q    <= 1'b0;
      pc_target_q  <= '0;
      halted_q     <= 1'b0;
      mul_busy_q   <= 1'b0;
      insn_count_q <= '0;
    end else begin
      pc_load_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (bus.id_valid) begin
            insn_count_q <= insn_count_d;
            if (bus.id_opcode == OP_MUL && MUL_LAT > 1) begin
              state_q     <= MUL_WAIT;
              cnt_q       <= CW'(MUL_LAT - 1);
              fetch_en_q  <= 1'b0;
              decode_en_q <= 1'b0;
              mul_busy_q  <= 1'b1;
            end else if ((bus.id_opcode == OP_BR) ||
                         (bus.id_opcode == OP_BNE && bus.br_taken)) begin
              state_q     <= FLUSH;
              cnt_q       <= CW'(FLUSH_CYC);
              pc_load_q   <= 1'b1;
              pc_target_q <= bus.br_target;
              flush_q     <= 1'b1;
              exec_en_q   <= 1'b0;
            end else if (bus.id_opcode == OP_HLT) begin
              state_q     <= HALTED;
              fetch_en_q  <= 1'b0;
              decode_en_q <= 1'b0;
              exec_en_q   <= 1'b0;
              halted_q    <= 1'b1;
            end
          end
        end
        MUL_WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q     <= RUN;
            fetch_en_q  <= 1'b1;
            decode_en_q <= 1'b1;
            mul_busy_q  <= 1'b0;
          end
        end
        FLUSH: begin
          // Counter was loaded on entry, so the entry cycle is flush cycle one.
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q   <= RUN;
            flush_q   <= 1'b0;
            exec_en_q <= 1'b1;
          end
        end
        HALTED: begin
          if (bus.resume) begin
            state_q     <= RUN;
            fetch_en_q  <= 1'b1;
            decode_en_q <= 1'b1;
            exec_en_q   <= 1'b1;
            halted_q    <= 1'b0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.fetch_en   = fetch_en_q;
  assign bus.decode_en  = decode_en_q;
  assign bus.exec_en    = exec_en_q;
  assign bus.flush      = flush_q;
  assign bus.pc_load    = pc_load_q;
  assign bus.pc_target  = pc_target_q;
  assign bus.halted     = halted_q;
  assign bus.mul_busy   = mul_busy_q;
  assign bus.insn_count = insn_count_q;
endmodule
